// File: rtl/pn_cmd_encoder_if.sv
// Command-port bundle between the spike/parameter sources, the encoder and the PN controller.
// The encoder uses the master view; the surrounding environment uses the slave view.
interface pn_cmd_encoder_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             spk_valid;
    logic             spk_ready;
    logic [6:0]       spk_id;
    logic             spk_rich;
    logic             prm_valid;
    logic             prm_ready;
    logic [1:0]       prm_target;
    logic [6:0]       prm_addr;
    logic [31:0]      prm_data;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_addr;
    logic [31:0]      cmd_data;
    logic [LVL_W-1:0] fifo_level;
    logic             err_bad_tgt;

    modport master (
        input  spk_valid, spk_id, spk_rich,
        input  prm_valid, prm_target, prm_addr, prm_data,
        input  flush, cmd_ready,
        output spk_ready, prm_ready, cmd_valid, cmd_addr, cmd_data,
        output fifo_level, err_bad_tgt
    );

    modport slave (
        output spk_valid, spk_id, spk_rich,
        output prm_valid, prm_target, prm_addr, prm_data,
        output flush, cmd_ready,
        input  spk_ready, prm_ready, cmd_valid, cmd_addr, cmd_data,
        input  fifo_level, err_bad_tgt
    );
endinterface

// File: rtl/pn_cmd_encoder.sv
// PN controller command initiator: queues fired-neuron spikes, pairs non-rich neighbours into
// one word, and interleaves parameter writes, presenting one registered word at a time.
module pn_cmd_encoder #(
    parameter int FIFO_DEPTH   = 16,
    parameter int PAIR_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    pn_cmd_encoder_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(PAIR_TIMEOUT) + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAIR_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_EMIT = 2'b10
    } state_t;

    function automatic logic [15:0] enc_param(input logic [1:0] tgt, input logic [6:0] addr);
        return {1'b1, 1'b0, tgt, 5'b00000, addr};
    endfunction

    function automatic logic [15:0] enc_rich(input logic [6:0] id);
        return {2'b01, 7'b0000000, id};
    endfunction

    function automatic logic [15:0] enc_single(input logic [6:0] id);
        return {2'b00, 7'b0000000, id};
    endfunction

    // A zero second neuron moves the first into the upper slot so bits[13:7]==0 still means "single".
    function automatic logic [15:0] enc_pair(input logic [6:0] a, input logic [6:0] b);
        if (b == 7'd0) begin
            return {2'b00, a, 7'b0000000};
        end else begin
            return {2'b00, b, a};
        end
    endfunction

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] mem_cnt_r;
    logic [LVL_W-1:0] level_r;
    logic             head_vld_r;
    logic [6:0]       head_id_r;
    logic             head_rich_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [6:0]       hold_a_r;
    logic [TMR_W-1:0] tmr_r;
    logic             cmd_valid_r;
    logic [15:0]      cmd_addr_r;
    logic [31:0]      cmd_data_r;
    logic             prm_ready_r;
    logic             err_bad_tgt_r;

    logic             push_s;
    logic             pop_s;
    logic             load_s;
    logic             pair_ok_s;
    logic             word_ld_s;
    logic [15:0]      word_addr_s;
    logic [31:0]      word_data_s;
    logic             prm_ack_s;
    logic             bad_tgt_s;
    logic             hold_ld_s;
    logic             tmr_clr_s;
    logic             tmr_inc_s;

    assign bus.spk_ready   = (level_r != LVL_FULL);
    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.cmd_addr    = cmd_addr_r;
    assign bus.cmd_data    = cmd_data_r;
    assign bus.prm_ready   = prm_ready_r;
    assign bus.err_bad_tgt = err_bad_tgt_r;
    assign bus.fifo_level  = level_r;

    assign push_s    = bus.spk_valid && bus.spk_ready;
    // The head register is a show-ahead stage: it refills from storage one edge after a write.
    assign load_s    = (!head_vld_r || pop_s) && (mem_cnt_r != LVL_ZERO);
    assign pair_ok_s = head_vld_r && !head_rich_r && !((hold_a_r == 7'd0) && (head_id_r == 7'd0));

    // Spike storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.spk_rich, bus.spk_id};
        end
    end

    // Storage pointers, storage count and total occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            mem_cnt_r <= LVL_ZERO;
            level_r   <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, load_s})
                2'b10:   mem_cnt_r <= mem_cnt_r + LVL_W'(1);
                2'b01:   mem_cnt_r <= mem_cnt_r - LVL_W'(1);
                default: mem_cnt_r <= mem_cnt_r;
            endcase
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Head-of-queue register presented to the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_vld_r  <= 1'b0;
            head_id_r   <= 7'd0;
            head_rich_r <= 1'b0;
        end else if (load_s) begin
            head_vld_r  <= 1'b1;
            head_rich_r <= mem_r[rd_ptr_r][7];
            head_id_r   <= mem_r[rd_ptr_r][6:0];
        end else if (pop_s) begin
            head_vld_r  <= 1'b0;
        end
    end

    // Next-state and word-building decisions.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        word_ld_s   = 1'b0;
        word_addr_s = 16'h0000;
        word_data_s = 32'h0000_0000;
        prm_ack_s   = 1'b0;
        bad_tgt_s   = 1'b0;
        hold_ld_s   = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request already acknowledged last cycle is not taken a second time.
                if (bus.prm_valid && !prm_ready_r) begin
                    prm_ack_s = 1'b1;
                    if (bus.prm_target != 2'b00) begin
                        word_ld_s   = 1'b1;
                        word_addr_s = enc_param(bus.prm_target, bus.prm_addr);
                        word_data_s = bus.prm_data;
                        state_nxt_s = ST_EMIT;
                    end else begin
                        bad_tgt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (head_vld_r) begin
                    pop_s = 1'b1;
                    if (head_rich_r) begin
                        word_ld_s   = 1'b1;
                        word_addr_s = enc_rich(head_id_r);
                        state_nxt_s = ST_EMIT;
                    end else begin
                        hold_ld_s   = 1'b1;
                        tmr_clr_s   = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (pair_ok_s) begin
                    pop_s       = 1'b1;
                    word_ld_s   = 1'b1;
                    word_addr_s = enc_pair(hold_a_r, head_id_r);
                    state_nxt_s = ST_EMIT;
                end else if (head_vld_r || bus.flush || bus.prm_valid || (tmr_r == TMR_LAST)) begin
                    // Any head that cannot pair (rich, or zero behind zero) stays queued.
                    word_ld_s   = 1'b1;
                    word_addr_s = enc_single(hold_a_r);
                    state_nxt_s = ST_EMIT;
                end else begin
                    tmr_inc_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_EMIT: begin
                if (bus.cmd_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, held spike and pairing timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            hold_a_r <= 7'd0;
            tmr_r    <= TMR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (hold_ld_s) begin
                hold_a_r <= head_id_r;
            end
            if (tmr_clr_s) begin
                tmr_r <= TMR_ZERO;
            end else if (tmr_inc_s) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end
        end
    end

    // Registered command word and one-cycle parameter status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid_r   <= 1'b0;
            cmd_addr_r    <= 16'h0000;
            cmd_data_r    <= 32'h0000_0000;
            prm_ready_r   <= 1'b0;
            err_bad_tgt_r <= 1'b0;
        end else begin
            cmd_valid_r   <= (state_nxt_s == ST_EMIT);
            prm_ready_r   <= prm_ack_s;
            err_bad_tgt_r <= bad_tgt_s;
            if (word_ld_s) begin
                cmd_addr_r <= word_addr_s;
                cmd_data_r <= word_data_s;
            end
        end
    end

endmodule

// File: tb/tb_pn_cmd_encoder.sv
// Directed bench for pn_cmd_encoder: hand-computed command words, latencies and flow control.
module tb_pn_cmd_encoder;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic [47:0] got_q[$];

    pn_cmd_encoder_if #(.FIFO_DEPTH(16)) bus ();

    pn_cmd_encoder #(.FIFO_DEPTH(16), .PAIR_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted command word as {addr, data}.
    always @(posedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) got_q.push_back({bus.cmd_addr, bus.cmd_data});
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one spike from a negedge; returns at the negedge after the accepting edge.
    task automatic push_spk(input logic [6:0] id, input logic rich);
        int n;
        n = 0;
        bus.spk_id    = id;
        bus.spk_rich  = rich;
        bus.spk_valid = 1'b1;
        while (!bus.spk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_wait", 48'(n < 200), 48'd1);
        @(posedge clk);
        @(negedge clk);
        bus.spk_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("word_count", 48'(got_q.size()), 48'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [47:0] word_at(input int i);
        if (i < got_q.size()) return got_q[i];
        else return 48'hFFFF_FFFF_FFFF;
    endfunction

    initial begin
        logic [6:0]  a7;
        logic [6:0]  b7;
        logic [15:0] pay_ref;
        int          max_lvl;
        bit          full_seen;
        bit          full_rdy_bad;
        bit          pay_chg;
        bit          have_ref;

        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.spk_valid = 1'b0; bus.spk_id = 7'd0; bus.spk_rich = 1'b0;
        bus.prm_valid = 1'b0; bus.prm_target = 2'b00; bus.prm_addr = 7'd0; bus.prm_data = 32'd0;
        bus.flush = 1'b0; bus.cmd_ready = 1'b1;
        idle(3);
        chk("rst_cmd_valid", 48'(bus.cmd_valid), 48'd0);
        chk("rst_prm_ready", 48'(bus.prm_ready), 48'd0);
        chk("rst_err", 48'(bus.err_bad_tgt), 48'd0);
        chk("rst_cmd_addr", 48'(bus.cmd_addr), 48'd0);
        chk("rst_cmd_data", 48'(bus.cmd_data), 48'd0);
        chk("rst_level", 48'(bus.fifo_level), 48'd0);
        chk("rst_spk_ready", 48'(bus.spk_ready), 48'd1);
        rst = 1'b1;
        idle(2);

        // 1: rich spike 5, valid after edge t+2
        push_spk(7'd5, 1'b1);
        chk("rich_t0", 48'(bus.cmd_valid), 48'd0);
        idle(1);
        chk("rich_t1", 48'(bus.cmd_valid), 48'd0);
        idle(1);
        chk("rich_t2", 48'(bus.cmd_valid), 48'd1);
        chk("rich_addr", 48'(bus.cmd_addr), 48'h4005);
        chk("rich_data", 48'(bus.cmd_data), 48'd0);
        idle(3);
        chk("rich_word", word_at(0), {16'h4005, 32'd0});
        got_q.delete();

        // 2: pairing
        push_spk(7'd3, 1'b0);
        push_spk(7'd9, 1'b0);
        wait_words(1, 20);
        chk("pair_3_9", word_at(0), {16'h0483, 32'd0});
        idle(12);
        chk("pair_only_one", 48'(got_q.size()), 48'd1);
        got_q.delete();
        push_spk(7'd7, 1'b0);
        push_spk(7'd0, 1'b0);
        wait_words(1, 20);
        chk("pair_7_0", word_at(0), {16'h0380, 32'd0});
        got_q.delete();
        push_spk(7'd0, 1'b0);
        push_spk(7'd0, 1'b0);
        wait_words(2, 60);
        chk("zero_a", word_at(0), {16'h0000, 32'd0});
        chk("zero_b", word_at(1), {16'h0000, 32'd0});
        idle(3);
        got_q.delete();

        // 3: lone spike timeout, then flush
        push_spk(7'd12, 1'b0);
        idle(9);
        chk("tmo_early", 48'(bus.cmd_valid), 48'd0);
        idle(1);
        chk("tmo_valid", 48'(bus.cmd_valid), 48'd1);
        chk("tmo_addr", 48'(bus.cmd_addr), 48'h000C);
        idle(3);
        got_q.delete();
        bus.flush = 1'b1;
        push_spk(7'd12, 1'b0);
        idle(2);
        chk("flush_early", 48'(bus.cmd_valid), 48'd0);
        idle(1);
        chk("flush_valid", 48'(bus.cmd_valid), 48'd1);
        chk("flush_addr", 48'(bus.cmd_addr), 48'h000C);
        bus.flush = 1'b0;
        idle(3);
        got_q.delete();

        // 4: parameter overtakes queued spikes; illegal target
        bus.prm_valid = 1'b1; bus.prm_target = 2'b10; bus.prm_addr = 7'h11; bus.prm_data = 32'hDEADBEEF;
        push_spk(7'd1, 1'b0);
        chk("prm_ready", 48'(bus.prm_ready), 48'd1);
        bus.prm_valid = 1'b0;
        push_spk(7'd2, 1'b0);
        push_spk(7'd4, 1'b0);
        wait_words(3, 40);
        chk("prm_word", word_at(0), {16'hA011, 32'hDEADBEEF});
        chk("prm_pair", word_at(1), {16'h0101, 32'd0});
        chk("prm_single", word_at(2), {16'h0004, 32'd0});
        got_q.delete();
        bus.prm_valid = 1'b1; bus.prm_target = 2'b00;
        idle(1);
        chk("bad_err", 48'(bus.err_bad_tgt), 48'd1);
        chk("bad_ready", 48'(bus.prm_ready), 48'd1);
        bus.prm_valid = 1'b0;
        idle(1);
        chk("bad_err_pulse", 48'(bus.err_bad_tgt), 48'd0);
        idle(5);
        chk("bad_no_cmd", 48'(got_q.size()), 48'd0);

        // 5: back-pressure, fill, release
        bus.cmd_ready = 1'b0;
        max_lvl = 0; full_seen = 1'b0; full_rdy_bad = 1'b0; pay_chg = 1'b0; have_ref = 1'b0;
        pay_ref = 16'h0000;
        fork
            begin
                for (int i = 1; i <= 20; i++) push_spk(7'(i), 1'b0);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
                    if (bus.fifo_level == 5'd16) begin
                        full_seen = 1'b1;
                        if (bus.spk_ready) full_rdy_bad = 1'b1;
                    end
                    if (bus.cmd_valid) begin
                        if (!have_ref) begin
                            pay_ref = bus.cmd_addr;
                            have_ref = 1'b1;
                        end else if (bus.cmd_addr != pay_ref) begin
                            pay_chg = 1'b1;
                        end
                    end
                end
                bus.cmd_ready = 1'b1;
            end
        join
        chk("stall_max_level", 48'(max_lvl), 48'd16);
        chk("stall_full_seen", 48'(full_seen), 48'd1);
        chk("stall_ready_low", 48'(full_rdy_bad), 48'd0);
        chk("stall_payload", 48'(pay_ref), 48'h0101);
        chk("stall_stable", 48'(pay_chg), 48'd0);
        wait_words(10, 300);
        for (int i = 0; i < 10; i++) begin
            a7 = 7'(2 * i + 1);
            b7 = 7'(2 * i + 2);
            chk("order_word", word_at(i), {2'b00, b7, a7, 32'd0});
        end
        idle(15);
        chk("order_no_extra", 48'(got_q.size()), 48'd10);
        got_q.delete();

        // 6: reset while a word is stalled
        bus.cmd_ready = 1'b0;
        push_spk(7'd7, 1'b1);
        push_spk(7'd8, 1'b1);
        idle(1);
        chk("r6_valid", 48'(bus.cmd_valid), 48'd1);
        chk("r6_level", 48'(bus.fifo_level), 48'd1);
        #2 rst = 1'b0;
        #1;
        chk("r6_async_valid", 48'(bus.cmd_valid), 48'd0);
        chk("r6_async_level", 48'(bus.fifo_level), 48'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.cmd_ready = 1'b1;
        got_q.delete();
        push_spk(7'd9, 1'b1);
        wait_words(1, 10);
        chk("r6_new_word", word_at(0), {16'h4009, 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
